// File: rtl/spi_flash_cmd_engine_pkg.sv
// Shared definitions for the SPI flash command engine.
//   - opcode constants for the commands the engine is used with
//   - FSM state encoding
//   - expected RDID identification bytes (manufacturer, type, capacity)
package spi_flash_pkg;

  localparam logic [7:0] RDID = 8'h9F;
  localparam logic [7:0] RDSR = 8'h05;
  localparam logic [7:0] WREN = 8'h06;
  localparam logic [7:0] READ = 8'h03;

  localparam logic [7:0] RDID_MFR_ID  = 8'h20;
  localparam logic [7:0] RDID_TYPE_ID = 8'h20;
  localparam logic [7:0] RDID_CAP_ID  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_TX_CMD,
    ST_TX_ADDR,
    ST_RX,
    ST_CS_HOLD
  } state_e;

endpackage

// File: rtl/spi_flash_cmd_engine_if.sv
// Command/response handshake between the control logic and the engine.
//   master : requester (drives start/opcode/addr/addr_en/resp_len)
//   slave  : engine    (drives busy/done/rx_byte/rx_valid/resp_data)
// resp_data byte k (k-th received) sits at [8k+7:8k].
interface spi_flash_cmd_engine_if #(
  parameter int MAX_RESP = 4,
  parameter int LEN_W    = 3
);
  logic                  start;
  logic [7:0]            opcode;
  logic [23:0]           addr;
  logic                  addr_en;
  logic [LEN_W-1:0]      resp_len;
  logic                  busy;
  logic                  done;
  logic [7:0]            rx_byte;
  logic                  rx_valid;
  logic [8*MAX_RESP-1:0] resp_data;

  modport master (
    output start, opcode, addr, addr_en, resp_len,
    input  busy, done, rx_byte, rx_valid, resp_data
  );

  modport slave (
    input  start, opcode, addr, addr_en, resp_len,
    output busy, done, rx_byte, rx_valid, resp_data
  );
endinterface

// File: rtl/spi_flash_cmd_engine_clk_gen.sv
// Half-period timer for the SPI serial clock.
//   CCLK, reset_n : system clock, async active-low reset
//   en            : count only while a transaction is in flight (outside IDLE)
//   run           : SPICLK toggles on half ticks (shift phases only)
//   half_tick     : end of any CLK_DIV-cycle half period
//   rise_tick     : half tick that should drive SPICLK high
//   fall_tick     : half tick that should drive SPICLK low
// During chip-select setup/hold run=0, so half periods elapse with SPICLK
// held low and the phase stays aligned to "next tick is a rise".
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CCLK,
  input  logic reset_n,
  input  logic en,
  input  logic run,
  output logic half_tick,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d;

  assign half_tick = en && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_tick = half_tick && run && !ph_q;
  assign fall_tick = half_tick && run &&  ph_q;

  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (!en) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (half_tick) begin
      cnt_d = '0;
      if (run) ph_d = !ph_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/spi_flash_cmd_engine.sv
// SPI mode-0 master command engine for the serial flash.
// Sends a 1-byte opcode, optionally a 24-bit address (MSB first), then reads
// 0..MAX_RESP response bytes, streaming each byte and packing them.
//   CCLK, reset_n : system clock, async active-low reset
//   cmd           : command handshake (slave side)
//   SPICLK        : serial clock, idles low
//   SPIMOSI       : serial data out, MSB first
//   SPISF         : chip select, active low
//   SPIMISO       : serial data in, sampled on the edge that raises SPICLK
module spi_flash_cmd_engine
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int MAX_RESP = 4,
  parameter int LEN_W    = 3
) (
  input  logic                   CCLK,
  input  logic                   reset_n,
  spi_flash_cmd_engine_if.slave  cmd,
  output logic                   SPICLK,
  output logic                   SPIMOSI,
  output logic                   SPISF,
  input  logic                   SPIMISO
);

  // Byte counter also walks the 3 address bytes, so it needs at least 2 bits.
  localparam int BC_W = (LEN_W < 2) ? 2 : LEN_W;
  localparam int RW   = 8 * MAX_RESP;

  state_e            state_q, state_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ss_q, ss_d;
  logic              done_q, done_d;
  logic              rxv_q, rxv_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic [RW-1:0]     resp_q, resp_d;
  logic [30:0]       tx_sr_q, tx_sr_d;   // bits still to send after the one on MOSI
  logic [6:0]        rx_sr_q, rx_sr_d;
  logic [2:0]        bit_q, bit_d;
  logic [BC_W-1:0]   byte_q, byte_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ae_q, ae_d;

  logic              half_tick, rise_tick, fall_tick;
  logic              run;
  logic [LEN_W-1:0]  len_clamped;
  state_e            after_tx;

  assign run = (state_q == ST_TX_CMD) || (state_q == ST_TX_ADDR) || (state_q == ST_RX);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .CCLK      (CCLK),
    .reset_n   (reset_n),
    .en        (state_q != ST_IDLE),
    .run       (run),
    .half_tick (half_tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign len_clamped = (cmd.resp_len > LEN_W'(MAX_RESP)) ? LEN_W'(MAX_RESP) : cmd.resp_len;
  assign after_tx    = (len_q != '0) ? ST_RX : ST_CS_HOLD;

  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    done_d    = 1'b0;
    rxv_d     = 1'b0;
    rx_byte_d = rx_byte_q;
    resp_d    = resp_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    len_d     = len_q;
    ae_d      = ae_q;

    unique case (state_q)
      ST_IDLE: begin
        // done_q blocks a start in the done cycle itself, so the deselect
        // lasts at least one cycle plus the preceding hold half period.
        if (cmd.start && !done_q) begin
          state_d = ST_CS_SETUP;
          ss_d    = 1'b0;
          mosi_d  = cmd.opcode[7];
          tx_sr_d = {cmd.opcode[6:0], cmd.addr};
          ae_d    = cmd.addr_en;
          len_d   = len_clamped;
          resp_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end

      ST_CS_SETUP: begin
        if (half_tick) state_d = ST_TX_CMD;
      end

      ST_TX_CMD, ST_TX_ADDR, ST_RX: begin
        if (rise_tick) begin
          sclk_d = 1'b1;
          if (state_q == ST_RX) begin
            rx_sr_d = {rx_sr_q[5:0], SPIMISO};
            if (bit_q == 3'd7) begin
              rx_byte_d = {rx_sr_q, SPIMISO};
              rxv_d     = 1'b1;
              for (int k = 0; k < MAX_RESP; k++) begin
                if (byte_q == BC_W'(k)) resp_d[8*k +: 8] = {rx_sr_q, SPIMISO};
              end
            end
          end
        end
        if (fall_tick) begin
          sclk_d  = 1'b0;
          bit_d   = bit_q + 3'd1;
          tx_sr_d = {tx_sr_q[29:0], 1'b0};
          if (bit_q == 3'd7) begin
            byte_d = byte_q + BC_W'(1);
            unique case (state_q)
              ST_TX_CMD: begin
                byte_d  = '0;
                state_d = ae_q ? ST_TX_ADDR : after_tx;
              end
              ST_TX_ADDR: begin
                if (byte_q == BC_W'(2)) begin
                  byte_d  = '0;
                  state_d = after_tx;
                end
              end
              default: begin
                if (byte_q == BC_W'(len_q) - BC_W'(1)) state_d = ST_CS_HOLD;
              end
            endcase
          end
          // Next bit goes out with the falling edge; MOSI rests low otherwise.
          mosi_d = ((state_d == ST_TX_CMD) || (state_d == ST_TX_ADDR)) ? tx_sr_q[30] : 1'b0;
        end
      end

      ST_CS_HOLD: begin
        if (half_tick) begin
          state_d = ST_IDLE;
          ss_d    = 1'b1;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      done_q    <= 1'b0;
      rxv_q     <= 1'b0;
      rx_byte_q <= '0;
      resp_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      len_q     <= '0;
      ae_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      done_q    <= done_d;
      rxv_q     <= rxv_d;
      rx_byte_q <= rx_byte_d;
      resp_q    <= resp_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      len_q     <= len_d;
      ae_q      <= ae_d;
    end
  end

  assign cmd.busy      = (state_q != ST_IDLE) || done_q;
  assign cmd.done      = done_q;
  assign cmd.rx_byte   = rx_byte_q;
  assign cmd.rx_valid  = rxv_q;
  assign cmd.resp_data = resp_q;
  assign SPICLK        = sclk_q;
  assign SPIMOSI       = mosi_q;
  assign SPISF         = ss_q;

endmodule
